// File: rtl/fifo_pkg.sv
// ============================================================================
// Module  : fifo_pkg
// Shared read-mode encodings and level-width helper for the FIFO family.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Level/pointer width: one extra bit so that a full FIFO is representable.
   function automatic int fifo_lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_tp.sv
// ============================================================================
// Module  : ram_tp
// Two-port RAM, one write port and one read port with 1-cycle read latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_tp
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   // Read register holds its value between reads; the FIFO relies on that.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rdata <= '0;
      end else if (re_i) begin
         r_rdata <= r_mem[raddr_i];
      end
   end

   assign rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fifo_fwft.sv
// ============================================================================
// Module  : fifo_fwft
// Single-clock FIFO: show-ahead or standard read, level flags, flush, sticky errors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_fwft
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 64,
   parameter int FWFT     = FIFO_MODE_FWFT,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         err_clr_i,
   input  logic                         wr_en_i,
   input  logic [WIDTH-1:0]             wr_data_i,
   output logic                         wr_full_o,
   output logic                         wr_afull_o,
   output logic [fifo_lvl_w(DEPTH)-1:0] wr_free_o,
   input  logic                         rd_en_i,
   output logic [WIDTH-1:0]             rd_data_o,
   output logic                         rd_valid_o,
   output logic                         rd_empty_o,
   output logic                         rd_aempty_o,
   output logic [fifo_lvl_w(DEPTH)-1:0] rd_avail_o,
   output logic                         ovf_o,
   output logic                         udf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = fifo_lvl_w(DEPTH);
   localparam logic [LW-1:0] c_DEPTH = LW'(DEPTH);
   localparam logic [LW-1:0] c_AF    = LW'(AF_LEVEL);
   localparam logic [LW-1:0] c_AE    = LW'(AE_LEVEL);

   logic [LW-1:0]    r_wr_ptr;
   logic [LW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_valid;
   logic             r_s1_vld;
   logic             r_ovf;
   logic             r_udf;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_ram_q;

   logic w_full;
   logic w_empty;
   logic w_wr;
   logic w_pop;
   logic w_load;
   logic w_fetch;
   logic w_unfetched;
   logic w_valid_nxt;

   assign w_full = (r_level == c_DEPTH);
   assign w_wr   = wr_en_i & ~w_full & ~flush_i;

   // r_rd_ptr is the RAM fetch pointer; r_s1_vld marks a fetched word waiting in the RAM read register.
   always_comb begin
      w_unfetched = (r_wr_ptr != r_rd_ptr);
      if (FWFT == FIFO_MODE_FWFT) begin
         w_empty     = ~r_valid;
         w_pop       = rd_en_i & r_valid & ~flush_i;
         w_load      = r_s1_vld & (~r_valid | w_pop) & ~flush_i;
         w_fetch     = w_unfetched & (~r_s1_vld | w_load) & ~flush_i;
         w_valid_nxt = w_load | (r_valid & ~w_pop);
      end else begin
         w_empty     = (r_level == '0);
         w_pop       = rd_en_i & ~w_empty & ~flush_i;
         w_load      = 1'b0;
         w_fetch     = w_pop;
         w_valid_nxt = w_pop;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_valid  <= 1'b0;
         r_s1_vld <= 1'b0;
         r_data   <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_s1_vld <= 1'b0;
         end else begin
            if (w_wr) begin
               r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_fetch) begin
               r_rd_ptr <= r_rd_ptr + LW'(1);
            end
            case ({w_wr, w_pop})
               2'b10:   r_level <= r_level + LW'(1);
               2'b01:   r_level <= r_level - LW'(1);
               default: r_level <= r_level;
            endcase
            r_valid  <= w_valid_nxt;
            r_s1_vld <= w_fetch | (r_s1_vld & ~w_load);
         end
         if (w_load) begin
            r_data <= w_ram_q;
         end
         // Setting an error wins over clearing it in the same cycle.
         r_ovf <= (wr_en_i & w_full & ~flush_i) | (r_ovf & ~err_clr_i);
         r_udf <= (rd_en_i & w_empty & ~flush_i) | (r_udf & ~err_clr_i);
      end
   end

   ram_tp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (w_wr),
      .waddr_i (r_wr_ptr[AW-1:0]),
      .wdata_i (wr_data_i),
      .re_i    (w_fetch),
      .raddr_i (r_rd_ptr[AW-1:0]),
      .rdata_o (w_ram_q)
   );

   assign wr_full_o   = w_full;
   assign wr_afull_o  = (r_level >= c_AF);
   assign wr_free_o   = c_DEPTH - r_level;
   assign rd_data_o   = (FWFT == FIFO_MODE_FWFT) ? r_data : w_ram_q;
   assign rd_valid_o  = r_valid;
   assign rd_empty_o  = w_empty;
   assign rd_aempty_o = (r_level <= c_AE);
   assign rd_avail_o  = r_level;
   assign ovf_o       = r_ovf;
   assign udf_o       = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_fifo_fwft.sv
// ============================================================================
// Module  : tb_fifo_fwft
// Directed bench for fifo_fwft: show-ahead instance plus a standard-read instance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_fwft;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // show-ahead instance
   logic       f_flush = 0, f_err_clr = 0, f_wr_en = 0, f_rd_en = 0;
   logic [7:0] f_wr_data = 0;
   logic       f_full, f_afull, f_valid, f_empty, f_aempty, f_ovf, f_udf;
   logic [3:0] f_free, f_avail;
   logic [7:0] f_rd_data;

   // standard-read instance
   logic       s_flush = 0, s_err_clr = 0, s_wr_en = 0, s_rd_en = 0;
   logic [7:0] s_wr_data = 0;
   logic       s_full, s_afull, s_valid, s_empty, s_aempty, s_ovf, s_udf;
   logic [3:0] s_free, s_avail;
   logic [7:0] s_rd_data;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] sb_q[$];
   logic [7:0] sb_exp;
   int         sb_lvl;
   logic       acc_w, acc_r, do_w, do_r;
   logic [7:0] wdat;

   always #5 clk = ~clk;

   fifo_fwft #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(f_flush), .err_clr_i(f_err_clr),
      .wr_en_i(f_wr_en), .wr_data_i(f_wr_data), .wr_full_o(f_full),
      .wr_afull_o(f_afull), .wr_free_o(f_free), .rd_en_i(f_rd_en),
      .rd_data_o(f_rd_data), .rd_valid_o(f_valid), .rd_empty_o(f_empty),
      .rd_aempty_o(f_aempty), .rd_avail_o(f_avail), .ovf_o(f_ovf), .udf_o(f_udf)
   );

   fifo_fwft #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_std (
      .clk_i(clk), .rst_i(rst), .flush_i(s_flush), .err_clr_i(s_err_clr),
      .wr_en_i(s_wr_en), .wr_data_i(s_wr_data), .wr_full_o(s_full),
      .wr_afull_o(s_afull), .wr_free_o(s_free), .rd_en_i(s_rd_en),
      .rd_data_o(s_rd_data), .rd_valid_o(s_valid), .rd_empty_o(s_empty),
      .rd_aempty_o(s_aempty), .rd_avail_o(s_avail), .ovf_o(s_ovf), .udf_o(s_udf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // ---- 1: reset values
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_empty",  32'(f_empty),   32'd1);
      check("rst_aempty", 32'(f_aempty),  32'd1);
      check("rst_free",   32'(f_free),    32'd8);
      check("rst_avail",  32'(f_avail),   32'd0);
      check("rst_full",   32'(f_full),    32'd0);
      check("rst_afull",  32'(f_afull),   32'd0);
      check("rst_ovf",    32'(f_ovf),     32'd0);
      check("rst_udf",    32'(f_udf),     32'd0);
      check("rst_valid",  32'(f_valid),   32'd0);
      check("rst_data",   32'(f_rd_data), 32'd0);
      check("rst_s_empty", 32'(s_empty),  32'd1);

      // ---- 2: fill, afull/full thresholds, overflow
      for (int i = 1; i <= 8; i++) begin
         f_wr_en = 1'b1; f_wr_data = 8'(i);
         tick();
         check("fill_avail", 32'(f_avail), 32'(i));
         check("fill_afull", 32'(f_afull), (i >= 6) ? 32'd1 : 32'd0);
         check("fill_full",  32'(f_full),  (i == 8) ? 32'd1 : 32'd0);
         check("fill_aempty", 32'(f_aempty), (i <= 2) ? 32'd1 : 32'd0);
      end
      check("full_free", 32'(f_free), 32'd0);
      f_wr_data = 8'hFF;
      tick();
      f_wr_en = 1'b0;
      check("ovf_set",   32'(f_ovf),   32'd1);
      check("ovf_avail", 32'(f_avail), 32'd8);
      f_err_clr = 1'b1;
      tick();
      f_err_clr = 1'b0;
      check("ovf_clr",   32'(f_ovf),     32'd0);
      check("head_valid", 32'(f_valid),  32'd1);
      check("head_data", 32'(f_rd_data), 32'h01);

      // ---- 3: back-to-back drain, then underflow
      f_rd_en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         check("drain_valid", 32'(f_valid),   32'd1);
         check("drain_data",  32'(f_rd_data), 32'(k));
         tick();
      end
      check("drain_empty", 32'(f_empty), 32'd1);
      check("drain_avail", 32'(f_avail), 32'd0);
      check("drain_udf0",  32'(f_udf),   32'd0);
      tick();
      f_rd_en = 1'b0;
      check("udf_set",   32'(f_udf),   32'd1);
      check("udf_avail", 32'(f_avail), 32'd0);

      // ---- 4: concurrent write+read at level 4 and at full
      f_err_clr = 1'b1;
      tick();
      f_err_clr = 1'b0;
      check("udf_clr", 32'(f_udf), 32'd0);
      for (int i = 0; i < 4; i++) begin
         f_wr_en = 1'b1; f_wr_data = 8'(8'h11 + i);
         tick();
      end
      f_wr_en = 1'b0;
      repeat (3) tick();
      check("l4_avail", 32'(f_avail),   32'd4);
      check("l4_head",  32'(f_rd_data), 32'h11);
      f_wr_en = 1'b1; f_wr_data = 8'h15; f_rd_en = 1'b1;
      tick();
      f_wr_en = 1'b0; f_rd_en = 1'b0;
      check("l4_wr_rd_avail", 32'(f_avail),   32'd4);
      check("l4_wr_rd_head",  32'(f_rd_data), 32'h12);
      for (int i = 0; i < 4; i++) begin
         f_wr_en = 1'b1; f_wr_data = 8'(8'h16 + i);
         tick();
      end
      check("l8_full",  32'(f_full),  32'd1);
      check("l8_avail", 32'(f_avail), 32'd8);
      f_wr_data = 8'hEE; f_rd_en = 1'b1;
      tick();
      f_wr_en = 1'b0; f_rd_en = 1'b0;
      check("l8_ovf",   32'(f_ovf),     32'd1);
      check("l8_avail", 32'(f_avail),   32'd7);
      check("l8_full0", 32'(f_full),    32'd0);
      check("l8_head",  32'(f_rd_data), 32'h13);
      f_rd_en = 1'b1;
      for (int k = 8'h13; k <= 8'h19; k++) begin
         check("l8_drain", 32'(f_rd_data), 32'(k));
         tick();
      end
      f_rd_en = 1'b0;
      check("l8_empty", 32'(f_empty), 32'd1);

      // ---- 6: flush at level 5 with a concurrent write
      for (int i = 0; i < 5; i++) begin
         f_wr_en = 1'b1; f_wr_data = 8'(8'h21 + i);
         tick();
      end
      f_wr_en = 1'b0;
      repeat (3) tick();
      check("fl_pre_avail", 32'(f_avail),   32'd5);
      check("fl_pre_head",  32'(f_rd_data), 32'h21);
      f_flush = 1'b1; f_wr_en = 1'b1; f_wr_data = 8'h77; f_rd_en = 1'b1;
      tick();
      f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0;
      check("fl_empty", 32'(f_empty),   32'd1);
      check("fl_avail", 32'(f_avail),   32'd0);
      check("fl_free",  32'(f_free),    32'd8);
      check("fl_ovf",   32'(f_ovf),     32'd1);
      check("fl_udf",   32'(f_udf),     32'd0);
      check("fl_valid", 32'(f_valid),   32'd0);
      check("fl_hold",  32'(f_rd_data), 32'h21);
      f_wr_en = 1'b1; f_wr_data = 8'hA5;
      tick();
      f_wr_en = 1'b0;
      check("lat_n0", 32'(f_valid), 32'd0);
      tick();
      check("lat_n1", 32'(f_valid), 32'd0);
      tick();
      check("lat_n2",    32'(f_valid),   32'd1);
      check("a5_data",   32'(f_rd_data), 32'hA5);
      check("a5_avail",  32'(f_avail),   32'd1);
      f_rd_en = 1'b1;
      tick();
      f_rd_en = 1'b0;
      check("a5_popped", 32'(f_empty), 32'd1);

      // ---- 5: random traffic on the standard-read instance
      sb_lvl = 0;
      for (int c = 0; c < 80; c++) begin
         do_w = ($urandom_range(0, 9) < 8);
         do_r = ($urandom_range(0, 9) < 7);
         wdat = 8'($urandom_range(0, 255));
         s_wr_en = do_w; s_rd_en = do_r; s_wr_data = wdat;
         acc_w = do_w && (sb_lvl < 8);
         acc_r = do_r && (sb_lvl > 0);
         if (acc_r) sb_exp = sb_q.pop_front();
         if (acc_w) sb_q.push_back(wdat);
         sb_lvl = sb_lvl + (acc_w ? 1 : 0) - (acc_r ? 1 : 0);
         tick();
         check("std_valid", 32'(s_valid), 32'(acc_r));
         if (acc_r) check("std_data", 32'(s_rd_data), 32'(sb_exp));
         check("std_avail", 32'(s_avail), 32'(sb_lvl));
         check("std_empty", 32'(s_empty), (sb_lvl == 0) ? 32'd1 : 32'd0);
      end
      s_wr_en = 1'b0; s_rd_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
